// File: rtl/gate_model_tester.sv
// Pattern generator, settle timer and 16-bit MISR around a combinational gate model.
// Define GMT_EXHAUSTIVE_EN to swap the LFSR for an N_IN-bit up-counter starting at 0.
module gate_model_tester #(
    parameter int unsigned N_IN   = 20,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned N_PAT  = 1024,
    parameter int unsigned SETTLE = 2,
    parameter logic [19:0] SEED   = 20'h00001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_OUT-1:0]  resp,
    input  logic [15:0]       exp_sig,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       signature,
    output logic [15:0]       pat_count
);

    localparam int unsigned CNT_W       = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [15:0] N_PAT_W     = 16'(N_PAT);
    localparam logic [15:0] MISR_POLY   = 16'h1021;

`ifdef GMT_EXHAUSTIVE_EN
    localparam int unsigned GEN_W = N_IN;
    localparam logic [GEN_W-1:0] GEN_INIT = '0;
`else
    localparam int unsigned GEN_W = 20;
    localparam logic [GEN_W-1:0] GEN_INIT = (SEED == 20'h0) ? 20'h00001 : SEED;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [GEN_W-1:0]   gen_q, gen_d, gen_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        misr_q, misr_d, misr_step;
    logic [15:0]        pcnt_q, pcnt_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_pat;

    // Next pattern source and signature compaction step.
    always_comb begin
`ifdef GMT_EXHAUSTIVE_EN
        gen_step = gen_q + GEN_W'(1);
`else
        gen_step = {gen_q[18:0], gen_q[19] ^ gen_q[16]};
`endif
        misr_step = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_POLY : 16'h0000) ^ 16'(resp);
        last_pat  = ({1'b0, pcnt_q} + 17'd1) >= {1'b0, N_PAT_W};
    end

    // busy/done are registered decodes of the current state, so they trail the state by one edge.
    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;
        pcnt_d  = pcnt_q;
        stim_d  = stim_q;
        busy_d  = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CAPTURE);
        done_d  = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    gen_d   = GEN_INIT;
                    misr_d  = 16'h0000;
                    pcnt_d  = 16'h0000;
                    done_d  = 1'b0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                stim_d  = N_IN'(gen_q);
                cnt_d   = CNT_INIT;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                misr_d  = misr_step;
                pcnt_d  = (pcnt_q >= N_PAT_W) ? pcnt_q : pcnt_q + 16'd1;
                gen_d   = gen_step;
                state_d = last_pat ? S_DONE : S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, but the partial signature and count stay visible.
        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            stim_d  = '0;
            misr_d  = misr_q;
            pcnt_d  = pcnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gen_q   <= GEN_INIT;
            cnt_q   <= '0;
            misr_q  <= 16'h0000;
            pcnt_q  <= 16'h0000;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            cnt_q   <= cnt_d;
            misr_q  <= misr_d;
            pcnt_q  <= pcnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = misr_q;
    assign pat_count = pcnt_q;
    assign pass      = done_q && (misr_q == exp_sig);

endmodule

// File: tb/tb_gate_model_tester.sv
// Self-checking bench for gate_model_tester: directed tables on small runs plus randomized
// runs against a reference model of the pattern source and signature.
`timescale 1ns/1ps
module tb_gate_model_tester;

    localparam int unsigned NPAT_C = 40;
    localparam int unsigned SET_C  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, abort_a, start_b, abort_b, start_c, abort_c;
    logic [15:0] exp_a, exp_b, exp_c;
    logic [9:0]  resp_a, resp_b, resp_c;
    logic [19:0] stim_a, stim_b, stim_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [15:0] sig_a, sig_b, sig_c, pc_a, pc_b, pc_c;
    logic [19:0] key_c;

    int tests_run = 0;
    int tests_failed = 0;

    // Stand-in combinational gate model for the randomized runs.
    function automatic logic [9:0] gate_fn(input logic [19:0] s, input logic [19:0] k);
        logic [19:0] x;
        x = s ^ k;
        return x[9:0] ^ (x[19:10] & x[14:5]);
    endfunction

    // Pattern source reference: shift-with-feedback, or plain counting in exhaustive mode.
    function automatic logic [19:0] gen_next(input logic [19:0] v);
        int unsigned x;
        x = 32'(v);
`ifdef GMT_EXHAUSTIVE_EN
        x = (x + 1) % (1 << 20);
`else
        x = ((x * 2) % (1 << 20)) | (((x >> 19) ^ (x >> 16)) & 1);
`endif
        return 20'(x);
    endfunction

    // Multiply by x, reduce modulo x^16+x^12+x^5+1, add the response.
    function automatic logic [15:0] misr_model(input logic [15:0] m, input logic [9:0] r);
        int unsigned x;
        x = 32'(m) * 2;
        if (x >= 32'h10000) x = x ^ 32'h11021;
        x = x ^ 32'(r);
        return 16'(x);
    endfunction

    gate_model_tester #(.N_IN(20), .N_OUT(10), .N_PAT(4), .SETTLE(1), .SEED(20'h00001)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .resp(resp_a), .exp_sig(exp_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_count(pc_a));

    gate_model_tester #(.N_IN(20), .N_OUT(10), .N_PAT(2), .SETTLE(2), .SEED(20'h00001)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .resp(resp_b), .exp_sig(exp_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_count(pc_b));

    gate_model_tester #(.N_IN(20), .N_OUT(10), .N_PAT(NPAT_C), .SETTLE(SET_C), .SEED(20'h00000)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .resp(resp_c), .exp_sig(exp_c),
        .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .pat_count(pc_c));

    assign resp_c = gate_fn(stim_c, key_c);

    // Record the applied vector each time a capture bumps the pattern count.
    logic [19:0] q_a[$];
    logic [19:0] q_c[$];
    logic [15:0] prev_a = 16'h0;
    logic [15:0] prev_c = 16'h0;
    always @(posedge clk) begin
        #2;
        if (pc_a != prev_a && pc_a != 16'h0) q_a.push_back(stim_a);
        if (pc_c != prev_c && pc_c != 16'h0) q_c.push_back(stim_c);
        prev_a = pc_a;
        prev_c = pc_c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One run on instance A; optional stray start pulse at cycle 'poke'.
    task automatic run_a(input logic [9:0] r, input logic [15:0] e, input int poke, output int cyc);
        resp_a = r;
        exp_a  = e;
        q_a.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 100) begin
            start_a = (cyc == poke);
            tick();
            cyc++;
        end
        start_a = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  resp;
        logic [15:0] exp_sig;
        logic [15:0] sig;
        logic        pass;
    } vec_t;

    vec_t        tbl [4];
    logic [19:0] stim_ref [4];

    task automatic check_a_run(input string nm, input int cyc, input vec_t v);
        int mism;
        check({nm, "_done_latency"}, 32'(cyc), 32'd13);
        check({nm, "_sig"}, 32'(sig_a), 32'(v.sig));
        check({nm, "_pass"}, 32'(pass_a), 32'(v.pass));
        check({nm, "_pat_count"}, 32'(pc_a), 32'd4);
        check({nm, "_busy_in_done"}, 32'(busy_a), 32'd0);
        check({nm, "_stim_count"}, 32'(q_a.size()), 32'd4);
        mism = 0;
        foreach (q_a[i]) if (i < 4 && q_a[i] !== stim_ref[i]) mism++;
        check({nm, "_stim_seq_mismatches"}, 32'(mism), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [19:0] v;
        logic [15:0] m;
        logic [19:0] exp_q[$];
        int mism, k;

        tbl[0] = '{10'h000, 16'h0000, 16'h0000, 1'b1};
        tbl[1] = '{10'h000, 16'h1234, 16'h0000, 1'b0};
        tbl[2] = '{10'h001, 16'h000F, 16'h000F, 1'b1};
        tbl[3] = '{10'h3FF, 16'h1405, 16'h1405, 1'b1};
`ifdef GMT_EXHAUSTIVE_EN
        stim_ref = '{20'h00000, 20'h00001, 20'h00002, 20'h00003};
`else
        stim_ref = '{20'h00001, 20'h00002, 20'h00004, 20'h00008};
`endif

        rst = 1'b1;
        start_a = 1'b1; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0; start_c = 1'b0; abort_c = 1'b0;
        exp_a = 16'h0; exp_b = 16'h0; exp_c = 16'h0;
        resp_a = 10'h0; resp_b = 10'h001; key_c = 20'h0;

        // Reset held two cycles with start asserted.
        repeat (2) tick();
        check("rst_stim", 32'(stim_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_sig", 32'(sig_a), 32'd0);
        check("rst_pat_count", 32'(pc_a), 32'd0);
        rst = 1'b0;
        start_a = 1'b0;
        repeat (2) tick();
        check("post_rst_idle_busy", 32'(busy_a), 32'd0);

        foreach (tbl[i]) begin
            run_a(tbl[i].resp, tbl[i].exp_sig, -1, cyc);
            check_a_run($sformatf("vec%0d", i), cyc, tbl[i]);
        end

        // Two-pattern run with resp held at 1.
        start_b = 1'b1; exp_b = 16'h0001;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        check("b_done_latency", 32'(cyc), 32'd9);
        check("b_sig", 32'(sig_b), 32'h0003);
        check("b_pass_wrong_exp", 32'(pass_b), 32'd0);
        check("b_pat_count", 32'(pc_b), 32'd2);
        exp_b = 16'h0003;
        #1;
        check("b_pass_right_exp", 32'(pass_b), 32'd1);

        // Abort while pattern 2 is settling.
        resp_a = 10'h0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("abort_pre_stim", 32'(stim_a), 32'h00002 - ((stim_ref[0] == 20'h0) ? 32'd1 : 32'd0));
        check("abort_pre_busy", 32'(busy_a), 32'd1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_stim", 32'(stim_a), 32'd0);
        check("abort_pat_count_kept", 32'(pc_a), 32'd1);
        repeat (3) tick();
        check("abort_stays_idle", 32'(busy_a), 32'd0);
        run_a(tbl[0].resp, tbl[0].exp_sig, -1, cyc);
        check_a_run("after_abort", cyc, tbl[0]);

        // Stray start while busy must not disturb the run.
        run_a(tbl[3].resp, tbl[3].exp_sig, 5, cyc);
        check_a_run("start_while_busy", cyc, tbl[3]);

        // start and abort together from DONE: abort wins.
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_done", 32'(done_a), 32'd0);
        check("start_abort_stim", 32'(stim_a), 32'd0);
        repeat (3) tick();
        check("start_abort_busy", 32'(busy_a), 32'd0);
        check("start_abort_pc_kept", 32'(pc_a), 32'd4);

        // Reset mid-run clears everything.
        resp_a = 10'h155;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_stim", 32'(stim_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_sig", 32'(sig_a), 32'd0);
        check("midrst_pat_count", 32'(pc_a), 32'd0);
        repeat (2) tick();
        check("midrst_idle", 32'(busy_a), 32'd0);

        // Randomized runs on the longer instance (SEED 0 behaves as 1).
        for (int r = 0; r < 8; r++) begin
            key_c = 20'($urandom);
            if (r % 2 == 1) begin
                k = int'($urandom_range(3, 190));
                start_c = 1'b1;
                tick();
                start_c = 1'b0;
                repeat (k) tick();
                abort_c = 1'b1;
                tick();
                abort_c = 1'b0;
                check($sformatf("rnd%0d_abort_busy", r), 32'(busy_c), 32'd0);
                check($sformatf("rnd%0d_abort_pc", r), 32'(pc_c), 32'(k / (SET_C + 2)));
                check($sformatf("rnd%0d_abort_stim", r), 32'(stim_c), 32'd0);
            end
`ifdef GMT_EXHAUSTIVE_EN
            v = 20'h00000;
`else
            v = 20'h00001;
`endif
            m = 16'h0;
            exp_q.delete();
            for (int p = 0; p < int'(NPAT_C); p++) begin
                exp_q.push_back(v);
                m = misr_model(m, gate_fn(v, key_c));
                v = gen_next(v);
            end
            exp_c = ($urandom_range(0, 1) == 1) ? m : 16'($urandom);
            q_c.delete();
            start_c = 1'b1;
            tick();
            start_c = 1'b0;
            cyc = 0;
            while (done_c !== 1'b1 && cyc < 400) begin tick(); cyc++; end
            check($sformatf("rnd%0d_latency", r), 32'(cyc), NPAT_C * (SET_C + 2) + 1);
            check($sformatf("rnd%0d_sig", r), 32'(sig_c), 32'(m));
            check($sformatf("rnd%0d_pc", r), 32'(pc_c), NPAT_C);
            check($sformatf("rnd%0d_pass", r), 32'(pass_c), 32'(exp_c == m));
            check($sformatf("rnd%0d_stim_count", r), 32'(q_c.size()), NPAT_C);
            mism = 0;
            foreach (q_c[i]) if (i < exp_q.size() && q_c[i] !== exp_q[i]) mism++;
            check($sformatf("rnd%0d_stim_seq_mismatches", r), 32'(mism), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
